// File: rtl/mult_pkg.sv
//------------------------------------------------------------------------------
// mult_pkg
// Shared opcode encodings, FSM state type and constants for the iterative
// shift-add multiplier.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  // LEGv8 multiply opcode encodings carried on the Op port
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SMULH = 2'b10;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  // Zero register: writes to it are suppressed
  localparam logic [4:0] XZR = 5'd31;

  // One shift-add step per operand bit
  localparam int DEFAULT_WIDTH = 64;
  localparam int ITERATIONS    = DEFAULT_WIDTH;

endpackage

`default_nettype wire

// File: rtl/iterative_multiplier_step.sv
//------------------------------------------------------------------------------
// mult_step
// Combinational single radix-2 shift-add step. When the multiplier LSB is set
// the multiplicand is added into the upper half of the accumulator; the
// accumulator (with the carry out of that add) and the multiplier are then
// both shifted right by one.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplr,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0]   o_mplr
);

  // One extra bit keeps the carry so no product bit is lost on the shift
  logic [WIDTH:0] w_sum;

  assign w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
                  (i_mplr[0] ? {1'b0, i_mcand} : {(WIDTH+1){1'b0}});
  assign o_acc  = {w_sum, i_acc[WIDTH-1:1]};
  assign o_mplr = {1'b0, i_mplr[WIDTH-1:1]};

endmodule

`default_nettype wire

// File: rtl/iterative_multiplier.sv
//------------------------------------------------------------------------------
// iterative_multiplier
// Multi-cycle 64-bit multiplier sitting downstream of the register file.
// Latches BusA/BusB/Op/Rd on Start, runs WIDTH shift-add steps, then drives
// the register file write port for exactly one cycle (MUL / UMULH / SMULH).
// Optional feature macro: MULT_SIGNED_EN enables SMULH (Op = 2'b10); when it
// is undefined Op = 2'b10 behaves as UMULH and no sign logic exists.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iterative_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int REGBITS = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   BusA,
  input  logic [WIDTH-1:0]   BusB,
  input  logic [REGBITS-1:0] Rd,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   BusW,
  output logic [REGBITS-1:0] RW,
  output logic               RegWr
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplr;
  logic [REGBITS-1:0]   r_rd;
  logic                 r_hi;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_start;
  logic                 w_op_hi;
  logic [WIDTH-1:0]     w_a_in;
  logic [WIDTH-1:0]     w_b_in;
  logic [2*WIDTH-1:0]   w_step_acc;
  logic [WIDTH-1:0]     w_step_mplr;
  logic [2*WIDTH-1:0]   w_prod;

  // Start is only honoured in IDLE; while busy it is dropped, not queued
  assign w_start = (r_state == IDLE) && Start;
  // Reserved opcode 2'b11 falls through to MUL (low half)
  assign w_op_hi = (Op == OP_UMULH) || (Op == OP_SMULH);

`ifdef MULT_SIGNED_EN
  logic w_op_signed;
  logic w_neg;
  logic r_neg;

  // SMULH multiplies magnitudes; the sign is restored on the WB output
  assign w_op_signed = (Op == OP_SMULH);
  assign w_a_in      = (w_op_signed && BusA[WIDTH-1]) ? (~BusA + 1'b1) : BusA;
  assign w_b_in      = (w_op_signed && BusB[WIDTH-1]) ? (~BusB + 1'b1) : BusB;
  assign w_neg       = w_op_signed && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
  assign w_prod      = r_neg ? (~r_acc + 1'b1) : r_acc;

  // Capture whether the final product needs two's-complement negation
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_neg <= 1'b0;
    end else if (w_start) begin
      r_neg <= w_neg;
    end
  end
`else
  assign w_a_in = BusA;
  assign w_b_in = BusB;
  assign w_prod = r_acc;
`endif

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_mplr  (r_mplr),
    .o_acc   (w_step_acc),
    .o_mplr  (w_step_mplr)
  );

  // Operand latch on Start, then one shift-add step per RUN cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_rd    <= '0;
      r_hi    <= 1'b0;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_acc   <= '0;
      r_mcand <= w_a_in;
      r_mplr  <= w_b_in;
      r_rd    <= Rd;
      r_hi    <= w_op_hi;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_step_acc;
      r_mplr  <= w_step_mplr;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // State register; reset wins over any pending Start
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: IDLE -> RUN on Start, RUN -> WB after the last step, WB -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Start) w_next = RUN;
      RUN:     if (r_cnt == c_LAST) w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are decoded from state; the write port is live only in WB
  always_comb begin
    Busy  = 1'b0;
    Done  = 1'b0;
    BusW  = '0;
    RW    = '0;
    RegWr = 1'b0;
    case (r_state)
      RUN: begin
        Busy = 1'b1;
      end
      WB: begin
        Busy  = 1'b1;
        Done  = 1'b1;
        BusW  = r_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        RW    = r_rd;
        // XZR retires silently; a reset landing in WB also blocks the write
        RegWr = (r_rd != REGBITS'(XZR)) && !Reset;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_multiplier.sv
//------------------------------------------------------------------------------
// tb_iterative_multiplier
// Self-checking bench: directed vector table, hand-written reset / ignore
// sequences, and randomized transactions against a product-based model.
// Honours MULT_SIGNED_EN the same way the design does.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iterative_multiplier;

  localparam int W  = 64;
  localparam int RB = 5;

`ifdef MULT_SIGNED_EN
  localparam logic [63:0] c_SMULH_EXP = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] c_SMULH_EXP = 64'd1;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  BusA;
  logic [W-1:0]  BusB;
  logic [RB-1:0] Rd;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  BusW;
  logic [RB-1:0] RW;
  logic          RegWr;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp_w;
    logic        exp_wr;
    bit          poke20;
  } vec_t;

  vec_t vecs[7];

  iterative_multiplier #(
    .WIDTH   (W),
    .REGBITS (RB)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .BusA  (BusA),
    .BusB  (BusB),
    .Rd    (Rd),
    .Busy  (Busy),
    .Done  (Done),
    .BusW  (BusW),
    .RW    (RW),
    .RegWr (RegWr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: full-width products computed with plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0] u;
    logic [127:0] s;
    u = {64'd0, a} * {64'd0, b};
    s = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    case (op)
      2'b01: return u[127:64];
`ifdef MULT_SIGNED_EN
      2'b10: return s[127:64];
`else
      2'b10: return u[127:64];
`endif
      default: return u[63:0];
    endcase
  endfunction

  // Issue one multiply (called at a negedge) and check its whole 66-cycle life
  task automatic run_txn(input string nm, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] exp_w, input logic exp_wr, input bit poke20);
    int          dones;
    bit          run_bad;
    bit          post_bad;
    logic [63:0] wb_w;
    logic [4:0]  wb_rw;
    logic        wb_wr;
    logic        wb_busy;
    dones    = 0;
    run_bad  = 1'b0;
    post_bad = 1'b1;
    wb_w     = '0;
    wb_rw    = '0;
    wb_wr    = 1'b0;
    wb_busy  = 1'b0;
    Start = 1'b1; Op = op; BusA = a; BusB = b; Rd = rd;
    @(posedge Clk);
    for (int c = 0; c <= 65; c++) begin
      @(negedge Clk);
      if (Done) dones++;
      if (c < 64 && (!Busy || RegWr || BusW != 0 || RW != 0 || Done)) run_bad = 1'b1;
      if (c == 64) begin
        wb_w = BusW; wb_rw = RW; wb_wr = RegWr; wb_busy = Busy;
      end
      if (c == 65) post_bad = Busy || RegWr || Done || BusW != 0 || RW != 0;
      if (c == 0) begin
        Start = 1'b0;
        Op    = 2'($urandom);
        BusA  = {$urandom, $urandom};
        BusB  = {$urandom, $urandom};
        Rd    = 5'($urandom);
      end
      if (poke20 && c == 20) begin
        Start = 1'b1; Rd = 5'd5;
      end
      if (c == 21) Start = 1'b0;
    end
    chk({nm, " run_phase_quiet"}, 128'(run_bad), 128'd0);
    chk({nm, " wb_busy"},         128'(wb_busy), 128'd1);
    chk({nm, " BusW"},            128'(wb_w), 128'(exp_w));
    chk({nm, " RW"},              128'(wb_rw), 128'(rd));
    chk({nm, " RegWr"},           128'(wb_wr), 128'(exp_wr));
    chk({nm, " done_count"},      128'(dones), 128'd1);
    chk({nm, " post_idle"},       128'(post_bad), 128'd0);
  endtask

  initial begin
    bit          saw_wr;
    bit          saw_done;
    logic [1:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [4:0]  rrd;

    vecs[0] = '{2'b00, 64'd3, 64'd5, 5'd2, 64'd15, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'd1, 1'b1, 1'b0};
    vecs[2] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
    vecs[3] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, c_SMULH_EXP, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
    vecs[5] = '{2'b11, 64'd6, 64'd7, 5'd9, 64'd42, 1'b1, 1'b0};
    vecs[6] = '{2'b00, 64'd7, 64'd7, 5'd31, 64'd49, 1'b0, 1'b1};

    Reset = 1'b1; Start = 1'b0; Op = '0; BusA = '0; BusB = '0; Rd = '0;
    repeat (3) @(negedge Clk);
    chk("in_reset outputs", {Busy, Done, RegWr, BusW, RW}, '0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("idle Busy",  128'(Busy),  128'd0);
    chk("idle RegWr", 128'(RegWr), 128'd0);
    chk("idle BusW",  128'(BusW),  128'd0);
    chk("idle RW",    128'(RW),    128'd0);
    chk("idle Done",  128'(Done),  128'd0);

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
              vecs[i].exp_w, vecs[i].exp_wr, vecs[i].poke20);
    end

    // Reset in the middle of RUN aborts the operation with no write
    saw_wr = 1'b0; saw_done = 1'b0;
    Start = 1'b1; Op = 2'b00; BusA = 64'd123; BusB = 64'd456; Rd = 5'd6;
    @(posedge Clk);
    for (int c = 0; c <= 70; c++) begin
      @(negedge Clk);
      if (RegWr) saw_wr = 1'b1;
      if (Done) saw_done = 1'b1;
      if (c == 0) Start = 1'b0;
      if (c == 30) begin
        chk("abort busy_before_reset", 128'(Busy), 128'd1);
        Reset = 1'b1;
      end
      if (c == 31) begin
        chk("abort busy_dropped", 128'(Busy), 128'd0);
        Reset = 1'b0;
      end
    end
    chk("abort no_regwr", 128'(saw_wr), 128'd0);
    chk("abort no_done",  128'(saw_done), 128'd0);
    run_txn("after_abort", 2'b00, 64'd10, 64'd10, 5'd6, 64'd100, 1'b1, 1'b0);

    // Randomized transactions against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       begin ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = {$urandom, $urandom}; end
        1:       begin ra = 64'($urandom_range(0, 1000)); rb = {$urandom, $urandom}; end
        2:       begin ra = {1'b1, 63'($urandom)}; rb = {1'b1, 63'({$urandom, $urandom})}; end
        default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
      endcase
      rrd = 5'($urandom_range(0, 31));
      run_txn($sformatf("rand%0d", i), rop, ra, rb, rrd, model(rop, ra, rb),
              rrd != 5'd31, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
